conv_ch_sched: RTL and testbench
================================

# conv_ch_sched

Channel scheduler for the 2x2-output 3x3 convolution multiplier.
- Per output tile, it sweeps all CH_NUM input channels, one per cycle, and drives the weight slice pointer (`base`) plus an activation read strobe to the datapath.
- It accumulates the four returned partial sums (LU/RU/LD/RD) across channels, then adds the bias, shifts and rounds, and saturates (optional ReLU).
- It presents one quantized 2x2 tile through a valid/ready handshake to the writeback stage.

## Interface
Parameters:
- CH_NUM, 24, input channels per tile (>=2)
- BW_PER_ACT, 16, activation and output width
- BW_PER_WEIGHT, 8, weight width
- BW_PER_BIAS, 8, bias width
- WEIGHT_PER_ADDR, 216, weights per weight-SRAM word (= 9*CH_NUM)
- BASE_BW, 11, width of `base`
- MUL_LAT, 2, cycles from an `rd_en` cycle to its sums being valid on `*_sum_in` (SRAM read + multiplier register)
- BIAS_SHIFT, 8, left shift applied to bias before the add
- OUT_SHIFT, 8, arithmetic right shift applied to the biased accumulator

Ports (`SW` = BW_PER_ACT+BW_PER_WEIGHT+8; `AW` = SW+5):
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin one tile; accepted only when `ready`=1
- ready  out  1  high only in IDLE
- rd_en  out  1  activation/weight read issued this cycle
- ch_idx  out  5  input channel being issued
- base  out  BASE_BW  MSB index of channel `ch_idx`'s 9-weight slice
- bias  in  BW_PER_BIAS  signed bias, sampled in FINAL
- LU_sum_in, RU_sum_in, LD_sum_in, RD_sum_in  in  SW each  signed partial sums
- out_valid  out  1  tile result valid
- out_ready  in  1  consumer accepts the tile
- out_LU, out_RU, out_LD, out_RD  out  BW_PER_ACT each  signed results

## Operation
- Reset values:
  - All outputs are 0 except `ready`=1.
  - State is IDLE.
  - Accumulators, channel counter and valid pipe are cleared.
- IDLE:
  - `start`=1 moves to RUN, with `ch_idx`=0.
  - The four `AW`-bit accumulators are cleared.
- RUN:
  - `rd_en`=1 every cycle.
  - `base` = WEIGHT_PER_ADDR*BW_PER_WEIGHT-1 - ch_idx*9*BW_PER_WEIGHT.
  - `ch_idx` increments each cycle.
  - After `ch_idx`=CH_NUM-1, the next state is DRAIN.
- DRAIN:
  - `rd_en`=0.
  - Stays here until the MUL_LAT-deep valid pipe is empty, then goes to FINAL.
- Accumulation:
  - Whenever the valid pipe output is 1, each accumulator += its sign-extended `*_sum_in`.
  - This is independent of state, so captures also occur during RUN.
- FINAL (1 cycle), per lane:
  - v = acc + (sext(bias) <<< BIAS_SHIFT)
  - r = (v + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, round half up; no rounding term when OUT_SHIFT=0
  - Saturate r to [-2^(BW_PER_ACT-1), 2^(BW_PER_ACT-1)-1].
  - Register the result onto `out_*` and go to DONE.
- DONE:
  - `out_valid`=1; `out_*` are held stable.
  - `out_valid` & `out_ready` returns to IDLE and deasserts `out_valid`.
- Boundary rules:
  - `start` outside IDLE is ignored.
  - `start` is never accepted in the same cycle as the DONE handshake; the earliest new start is the next cycle.
  - `out_ready` outside DONE is ignored.
  - `rst_n`=0 in any state aborts the tile immediately: reset values, and no `out_valid` pulse.
  - Saturation applies per lane, independently.

## Timing
- Cycle 0 is the edge sampling `start`=1.
- `rd_en` is high for cycles 1..CH_NUM exactly.
- The sum for the channel issued in cycle c is added at edge c+MUL_LAT.
- `out_*` load at edge CH_NUM+MUL_LAT+1; `out_valid` is high from that cycle on.
- Latency from start to `out_valid`: CH_NUM+MUL_LAT+1 = 27 cycles at defaults.
- Throughput is one tile per CH_NUM+MUL_LAT+3 cycles with `out_ready` tied high.
- `ready`/`out_valid` are registered and never both high.

## Configuration
- `CONV_SCHED_RELU_EN` defined: after saturation, negative lane results are forced to 0 before registering.
- Not defined: signed saturated results pass through unchanged; there is no ReLU logic.

## Test plan
- Base sweep: one tile at defaults -> `rd_en` high 24 cycles; `base` = 1727, 1655, ..., 71 (step -72); `ch_idx` 0..23.
- Accumulate: all sums = 10 every channel, bias=1 -> acc 240, v=496, out = (496+128)>>>8 = 2 on all lanes; `out_valid` at cycle 27.
- Saturation and sign: LU = 2^26 and RU = -2^26 per channel, bias=0 -> out_LU=32767, out_RU=-32768. With `CONV_SCHED_RELU_EN` -> out_RU=0.
- Backpressure: `out_ready`=0 for 10 cycles in DONE -> `out_valid` and `out_*` stable. `start` pulsed during DONE is ignored; `ready` rises the cycle after the handshake.
- Reset mid-run: `rst_n`=0 at cycle 12 -> next cycle all outputs 0, `ready`=1. A fresh tile of sums=10, bias=1 -> out=2 (no residue from the aborted tile).
- Lane independence: LU=1, RU=2, LD=3, RD=4 per channel, bias=0, OUT_SHIFT=0 override -> outputs 24, 48, 72, 96.

Source files
------------

// File: rtl/conv_ch_sched.sv
// conv_ch_sched: sweeps the input channels of one 2x2 output tile, accumulates the returned
// partial sums, then biases, rounds and saturates them. Define CONV_SCHED_RELU_EN to clamp negatives to 0.
module conv_ch_sched #(
  parameter int CH_NUM          = 24,
  parameter int BW_PER_ACT      = 16,
  parameter int BW_PER_WEIGHT   = 8,
  parameter int BW_PER_BIAS     = 8,
  parameter int WEIGHT_PER_ADDR = 216,
  parameter int BASE_BW         = 11,
  parameter int MUL_LAT         = 2,
  parameter int BIAS_SHIFT      = 8,
  parameter int OUT_SHIFT       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  output logic                                 ready,
  output logic                                 rd_en,
  output logic [4:0]                           ch_idx,
  output logic [BASE_BW-1:0]                   base,
  input  logic [BW_PER_BIAS-1:0]               bias,
  input  logic [BW_PER_ACT+BW_PER_WEIGHT+7:0]  LU_sum_in,
  input  logic [BW_PER_ACT+BW_PER_WEIGHT+7:0]  RU_sum_in,
  input  logic [BW_PER_ACT+BW_PER_WEIGHT+7:0]  LD_sum_in,
  input  logic [BW_PER_ACT+BW_PER_WEIGHT+7:0]  RD_sum_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [BW_PER_ACT-1:0]                out_LU,
  output logic [BW_PER_ACT-1:0]                out_RU,
  output logic [BW_PER_ACT-1:0]                out_LD,
  output logic [BW_PER_ACT-1:0]                out_RD,
  output logic [2:0]                           dbg_state
);

  localparam int SW        = BW_PER_ACT + BW_PER_WEIGHT + 8;
  localparam int AW        = SW + 5;
  localparam int BIAS_W    = BW_PER_BIAS + BIAS_SHIFT;
  localparam int VW        = ((AW > BIAS_W) ? AW : BIAS_W) + 2;
  localparam int BASE_TOP  = WEIGHT_PER_ADDR * BW_PER_WEIGHT - 1;
  localparam int CH_STRIDE = 9 * BW_PER_WEIGHT;

  localparam logic signed [VW-1:0] RND     = (VW'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [VW-1:0] SAT_MAX = {{(VW-BW_PER_ACT+1){1'b0}}, {(BW_PER_ACT-1){1'b1}}};
  localparam logic signed [VW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            ch_idx_q, ch_idx_d;
  logic [MUL_LAT-1:0]    vpipe_q, vpipe_d;
  logic signed [AW-1:0]  acc_q [4];
  logic signed [AW-1:0]  acc_d [4];
  logic [BW_PER_ACT-1:0] out_q [4];
  logic [BW_PER_ACT-1:0] out_d [4];
  logic signed [SW-1:0]  sum_in [4];

  assign sum_in[0] = LU_sum_in;
  assign sum_in[1] = RU_sum_in;
  assign sum_in[2] = LD_sum_in;
  assign sum_in[3] = RD_sum_in;

  function automatic logic [BW_PER_ACT-1:0] quant(input logic signed [AW-1:0] a,
                                                  input logic signed [BW_PER_BIAS-1:0] b);
    logic signed [VW-1:0] v;
    logic signed [VW-1:0] r;
    v = VW'(a) + (VW'(b) <<< BIAS_SHIFT);
    r = (v + RND) >>> OUT_SHIFT;
    if (r > SAT_MAX) r = SAT_MAX;
    else if (r < SAT_MIN) r = SAT_MIN;
`ifdef CONV_SCHED_RELU_EN
    if (r < 0) r = '0;
`endif
    return BW_PER_ACT'(r);
  endfunction

  // Output handshake: the tile transfers on a cycle where out_valid && out_ready; out_valid is only
  // high in DONE and out_* stay constant until that transfer. start transfers only while ready (IDLE).
  always_comb begin
    state_d  = state_q;
    ch_idx_d = ch_idx_q;
    out_d    = out_q;
    vpipe_d[0] = (state_q == S_RUN);
    for (int i = 1; i < MUL_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    for (int i = 0; i < 4; i++) begin
      acc_d[i] = acc_q[i];
      if (vpipe_q[MUL_LAT-1]) acc_d[i] = acc_q[i] + AW'(sum_in[i]);
    end
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < 4; i++) acc_d[i] = '0;
        if (start) begin
          state_d  = S_RUN;
          ch_idx_d = '0;
        end
      end
      S_RUN: begin
        if (ch_idx_q == 5'(CH_NUM - 1)) begin
          state_d  = S_DRAIN;
          ch_idx_d = '0;
        end else begin
          ch_idx_d = ch_idx_q + 5'd1;
        end
      end
      // Leave as the last in-flight sum is being added, so acc_q is complete in FINAL.
      S_DRAIN: if (vpipe_d == '0) state_d = S_FINAL;
      S_FINAL: begin
        for (int i = 0; i < 4; i++) out_d[i] = quant(acc_q[i], bias);
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_idx_q <= '0;
      vpipe_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      vpipe_q  <= vpipe_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign rd_en     = (state_q == S_RUN);
  assign out_valid = (state_q == S_DONE);
  assign ch_idx    = ch_idx_q;
  assign base      = rd_en ? BASE_BW'(BASE_TOP - int'(ch_idx_q) * CH_STRIDE) : '0;
  assign out_LU    = out_q[0];
  assign out_RU    = out_q[1];
  assign out_LD    = out_q[2];
  assign out_RD    = out_q[3];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_ch_sched.sv
// Bench for conv_ch_sched: a datapath model returns per-channel sums MUL_LAT edges after each read,
// and a scoreboard of expected tiles is checked at every output handshake (default and OUT_SHIFT=0 builds).
module tb_conv_ch_sched;

  localparam int CH  = 24;
  localparam int ML  = 2;
  localparam int LAT = CH + ML + 1;
  localparam int M_CONST = 0, M_SAT = 1, M_LANE = 2, M_RAND = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, out_ready;
  logic [7:0]  bias;
  logic [31:0] lu_sum, ru_sum, ld_sum, rd_sum;

  logic        ready_a, rd_en_a, out_valid_a;
  logic [4:0]  ch_idx_a;
  logic [10:0] base_a;
  logic [15:0] out_lu_a, out_ru_a, out_ld_a, out_rd_a;
  logic [2:0]  dbg_a;
  logic        ready_b, rd_en_b, out_valid_b;
  logic [4:0]  ch_idx_b;
  logic [10:0] base_b;
  logic [15:0] out_lu_b, out_ru_b, out_ld_b, out_rd_b;
  logic [2:0]  dbg_b;

  int vectors = 0;
  int miscompares = 0;
  int tbl [4][CH];
  logic [5:0] hist [ML+1] = '{default: '0};
  logic [63:0] exp_q[$];
  logic [63:0] exp2_q[$];

  always #5 clk = ~clk;

  conv_ch_sched dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready_a), .rd_en(rd_en_a),
    .ch_idx(ch_idx_a), .base(base_a), .bias(bias),
    .LU_sum_in(lu_sum), .RU_sum_in(ru_sum), .LD_sum_in(ld_sum), .RD_sum_in(rd_sum),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_LU(out_lu_a), .out_RU(out_ru_a), .out_LD(out_ld_a), .out_RD(out_rd_a),
    .dbg_state(dbg_a)
  );

  conv_ch_sched #(.OUT_SHIFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready_b), .rd_en(rd_en_b),
    .ch_idx(ch_idx_b), .base(base_b), .bias(bias),
    .LU_sum_in(lu_sum), .RU_sum_in(ru_sum), .LD_sum_in(ld_sum), .RD_sum_in(rd_sum),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_LU(out_lu_b), .out_RU(out_ru_b), .out_LD(out_ld_b), .out_RD(out_rd_b),
    .dbg_state(dbg_b)
  );

  // Datapath model: a read seen at edge n returns its sums for edge n+ML; otherwise drive junk.
  always @(negedge clk) begin
    for (int i = ML; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {rd_en_a, ch_idx_a};
    if (hist[ML][5]) begin
      lu_sum = tbl[0][hist[ML][4:0]];
      ru_sum = tbl[1][hist[ML][4:0]];
      ld_sum = tbl[2][hist[ML][4:0]];
      rd_sum = tbl[3][hist[ML][4:0]];
    end else begin
      lu_sum = $urandom; ru_sum = $urandom; ld_sum = $urandom; rd_sum = $urandom;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_lane(input longint acc, input int b, input int sh);
    longint v, r;
    v = acc + longint'(b) * 256;
    if (sh > 0) r = (v + (longint'(1) << (sh - 1))) >>> sh;
    else r = v;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef CONV_SCHED_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  function automatic logic [63:0] ref_tile(input int b, input int sh);
    logic [63:0] res;
    longint acc;
    for (int l = 0; l < 4; l++) begin
      acc = 0;
      for (int c = 0; c < CH; c++) acc += longint'(tbl[l][c]);
      res[l*16 +: 16] = ref_lane(acc, b, sh);
    end
    return res;
  endfunction

  task automatic fill_tbl(input int mode);
    for (int c = 0; c < CH; c++) begin
      for (int l = 0; l < 4; l++) begin
        case (mode)
          M_CONST: tbl[l][c] = 10;
          M_LANE:  tbl[l][c] = l + 1;
          default: tbl[l][c] = int'($urandom_range(0, 2097152)) - 1048576;
        endcase
      end
      if (mode == M_SAT) begin
        tbl[0][c] = 1 << 26;
        tbl[1][c] = -(1 << 26);
      end
    end
  endtask

  task automatic check_tile(input string tag, input logic [63:0] e, input logic [63:0] e2);
    check({tag, "_lu"}, out_lu_a, e[15:0]);
    check({tag, "_ru"}, out_ru_a, e[31:16]);
    check({tag, "_ld"}, out_ld_a, e[47:32]);
    check({tag, "_rd"}, out_rd_a, e[63:48]);
    check({tag, "_lu_s0"}, out_lu_b, e2[15:0]);
    check({tag, "_ru_s0"}, out_ru_b, e2[31:16]);
    check({tag, "_ld_s0"}, out_ld_b, e2[47:32]);
    check({tag, "_rd_s0"}, out_rd_b, e2[63:48]);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_tile(input int mode, input int b, input int hold,
                          input bit start_in_done, input bit start_at_hs);
    logic [63:0] e, e2;
    int n;
    fill_tbl(mode);
    bias = 8'(b);
    exp_q.push_back(ref_tile(b, 8));
    exp2_q.push_back(ref_tile(b, 0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    check("run_state", dbg_a, 3'd1);
    while (!out_valid_a && n < 200) begin
      check("busy_ready", ready_a, 1'b0);
      check("rd_en", rd_en_a, n < CH);
      if (n < CH) begin
        check("ch_idx", ch_idx_a, n);
        check("base", base_a, 1727 - 72 * n);
      end
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    check("done_state", dbg_a, 3'd4);
    check("valid_s0", out_valid_b, 1'b1);
    check("sb_depth", exp_q.size(), 1);
    e  = exp_q.pop_front();
    e2 = exp2_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("bp_valid", out_valid_a, 1'b1);
      check("bp_ready", ready_a, 1'b0);
      check_tile("bp", e, e2);
      start = start_in_done && (h == hold / 2);
      @(negedge clk);
    end
    start = 1'b0;
    check("hs_valid", out_valid_a, 1'b1);
    check_tile("tile", e, e2);
    out_ready = 1'b1;
    start = start_at_hs;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("post_hs_ready", ready_a, 1'b1);
    check("post_hs_valid", out_valid_a, 1'b0);
    if (start_at_hs) begin
      @(negedge clk);
      check("hs_start_ignored", ready_a, 1'b1);
      check("hs_start_no_rd", rd_en_a, 1'b0);
    end
  endtask

  task automatic abort_tile(input int at);
    fill_tbl(M_RAND);
    bias = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (at) @(negedge clk);
    check("abort_running", rd_en_a, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ready", ready_a, 1'b1);
    check("abort_rd_en", rd_en_a, 1'b0);
    check("abort_ch_idx", ch_idx_a, 5'd0);
    check("abort_base", base_a, 11'd0);
    check("abort_valid", out_valid_a, 1'b0);
    check("abort_outs", {out_rd_a, out_ld_a, out_ru_a, out_lu_a}, 64'd0);
    check("abort_state", dbg_a, 3'd0);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid_a, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; bias = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_a, 1'b1);
    check("rst_rd_en", rd_en_a, 1'b0);
    check("rst_ch_idx", ch_idx_a, 5'd0);
    check("rst_base", base_a, 11'd0);
    check("rst_valid", out_valid_a, 1'b0);
    check("rst_outs", {out_rd_a, out_ld_a, out_ru_a, out_lu_a}, 64'd0);
    check("rst_state", dbg_a, 3'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("idle_ready", ready_a, 1'b1);
    check("idle_ack_ignored", out_valid_a, 1'b0);
    out_ready = 1'b0;

    run_tile(M_CONST, 1, 0, 1'b0, 1'b0);
    run_tile(M_SAT, 0, 10, 1'b1, 1'b0);
    run_tile(M_LANE, 0, 0, 1'b0, 1'b1);
    abort_tile(11);
    run_tile(M_CONST, 1, 0, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++)
      run_tile(M_RAND, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)), 1'b0, 1'b0);

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
